// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals for the two-requester ALU arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface alu_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*XLEN-1:0] req_rs1;
    logic [2*XLEN-1:0] req_rs2;
    logic [5:0]        req_funct3;
    logic [13:0]       req_funct7;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [XLEN-1:0]   resp_rd;
    logic              resp_z;
    logic [XLEN-1:0]   alu_rs1;
    logic [XLEN-1:0]   alu_rs2;
    logic [2:0]        alu_funct3;
    logic [6:0]        alu_funct7;
    logic [XLEN-1:0]   alu_rd;
    logic              alu_z;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_funct3, req_funct7, resp_ready, alu_rd, alu_z,
        output req_ready, resp_valid, resp_rd, resp_z, alu_rs1, alu_rs2, alu_funct3, alu_funct7
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_funct3, req_funct7, resp_ready, alu_rd, alu_z,
        input  req_ready, resp_valid, resp_rd, resp_z, alu_rs1, alu_rs2, alu_funct3, alu_funct7
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU with fixed latency ALU_LAT.
// One transaction in flight: IDLE grants and latches, EXEC waits out the ALU, RESP holds
// the captured result until the owner accepts it.
module alu_arbiter #(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              last_reg;
    logic              owner_reg;
    logic [XLEN-1:0]   rs1_reg, rs2_reg, rd_reg;
    logic [2:0]        f3_reg;
    logic [6:0]        f7_reg;
    logic              z_reg;

    logic              grant;
    logic              accept;
    logic              capture;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;

    // Per-requester views of the packed request buses
    logic [XLEN-1:0]   rs1_sl [2];
    logic [XLEN-1:0]   rs2_sl [2];
    logic [2:0]        f3_sl  [2];
    logic [6:0]        f7_sl  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_slice
        assign rs1_sl[gi] = bus.req_rs1[gi*XLEN +: XLEN];
        assign rs2_sl[gi] = bus.req_rs2[gi*XLEN +: XLEN];
        assign f3_sl[gi]  = bus.req_funct3[gi*3 +: 3];
        assign f7_sl[gi]  = bus.req_funct7[gi*7 +: 7];
    end

    // Next-state, grant selection and handshake outputs
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        grant      = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        case (state_reg)
            IDLE: begin
                // A tie goes to whoever was not granted last; reset also blocks acceptance
                if (!rst && (bus.req_valid != 2'b00)) begin
                    grant      = (bus.req_valid == 2'b11) ? ~last_reg : ~bus.req_valid[0];
                    req_ready  = grant ? 2'b10 : 2'b01;
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Counter stops at the last EXEC cycle, so it can never wrap
                if (cnt_reg == LAT_LAST) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                resp_valid = owner_reg ? 2'b10 : 2'b01;
                if (bus.resp_ready[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, arbitration history, operand latches and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            f3_reg    <= '0;
            f7_reg    <= '0;
            rd_reg    <= '0;
            z_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                last_reg  <= grant;
                owner_reg <= grant;
                rs1_reg   <= rs1_sl[grant];
                rs2_reg   <= rs2_sl[grant];
                f3_reg    <= f3_sl[grant];
                f7_reg    <= f7_sl[grant];
            end
            if (capture) begin
                rd_reg <= bus.alu_rd;
                z_reg  <= bus.alu_z;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rd    = rd_reg;
    assign bus.resp_z     = z_reg;
    assign bus.alu_rs1    = rs1_reg;
    assign bus.alu_rs2    = rs2_reg;
    assign bus.alu_funct3 = f3_reg;
    assign bus.alu_funct7 = f7_reg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 (ALU_LAT=1) gets directed scenarios then random traffic;
// instance 1 (ALU_LAT=3) runs back-to-back requests from requester 1 throughout.
// Each instance has a transaction-level scoreboard that predicts grants, latency and results.
module tb_alu_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(XLEN)) bus [2] ();

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference ALU: RV32-style register ops; bit XLEN carries the zero flag
    function automatic logic [XLEN:0] alu_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [2:0] f3, input logic [6:0] f7);
        logic [XLEN-1:0] r;
        case (f3)
            3'd0: r = f7[5] ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {(r == '0), r};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 1 : 3;

        alu_arbiter #(.XLEN(XLEN), .ALU_LAT(L)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[gi])
        );

        // Shared ALU model with L cycles from operands to result
        logic [XLEN:0] cv, aout;
        assign cv = alu_fn(bus[gi].alu_rs1, bus[gi].alu_rs2, bus[gi].alu_funct3, bus[gi].alu_funct7);
        if (L == 1) begin : g_comb
            assign aout = cv;
        end else begin : g_pipe
            logic [XLEN:0] sr [L-1];
            always @(posedge clk) begin
                sr[0] <= cv;
                for (int k = 1; k < L - 1; k++) sr[k] <= sr[k-1];
            end
            assign aout = sr[L-2];
        end
        assign bus[gi].alu_rd = aout[XLEN-1:0];
        assign bus[gi].alu_z  = aout[XLEN];

        // Scoreboard: one outstanding transaction, round-robin grants, fixed latency
        int              cyc   = 0;
        int              acc   = 0;
        int              g     = 0;
        logic            busy  = 1'b0;
        logic            lg    = 1'b1;
        logic            owner = 1'b0;
        logic [XLEN-1:0] l_rs1 = '0;
        logic [6:0]      l_f7  = '0;
        logic [XLEN:0]   e_res = '0;
        logic [1:0]      e_ready, e_rv;

        always @(negedge clk) begin
            if (rst) begin
                busy  = 1'b0;
                lg    = 1'b1;
                l_rs1 = '0;
                l_f7  = '0;
            end else begin
                e_ready = 2'b00;
                g = 0;
                if (!busy && bus[gi].req_valid != 2'b00) begin
                    if (bus[gi].req_valid == 2'b11) g = lg ? 0 : 1;
                    else g = bus[gi].req_valid[0] ? 0 : 1;
                    e_ready = (g == 1) ? 2'b10 : 2'b01;
                end
                e_rv = (busy && cyc >= acc + 1 + L) ? (owner ? 2'b10 : 2'b01) : 2'b00;
                check($sformatf("i%0d req_ready", gi), bus[gi].req_ready, e_ready);
                check($sformatf("i%0d resp_valid", gi), bus[gi].resp_valid, e_rv);
                check($sformatf("i%0d alu_rs1", gi), bus[gi].alu_rs1, l_rs1);
                check($sformatf("i%0d alu_funct7", gi), bus[gi].alu_funct7, l_f7);
                if (e_rv != 2'b00) begin
                    check($sformatf("i%0d resp_rd", gi), bus[gi].resp_rd, e_res[XLEN-1:0]);
                    check($sformatf("i%0d resp_z", gi), bus[gi].resp_z, e_res[XLEN]);
                    if (bus[gi].resp_ready[owner]) begin
                        busy = 1'b0;
                        $display("i%0d txn done: owner %0d rd %h z %0d at cycle %0d",
                                 gi, owner, e_res[XLEN-1:0], e_res[XLEN], cyc);
                    end
                end
                if (e_ready != 2'b00) begin
                    busy  = 1'b1;
                    owner = 1'(g);
                    lg    = 1'(g);
                    acc   = cyc;
                    l_rs1 = bus[gi].req_rs1[g*XLEN +: XLEN];
                    l_f7  = bus[gi].req_funct7[g*7 +: 7];
                    e_res = alu_fn(l_rs1, bus[gi].req_rs2[g*XLEN +: XLEN],
                                   bus[gi].req_funct3[g*3 +: 3], l_f7);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic [6:0] f7);
        bus[0].req_rs1[r*XLEN +: XLEN] = a;
        bus[0].req_rs2[r*XLEN +: XLEN] = b;
        bus[0].req_funct3[r*3 +: 3]    = f3;
        bus[0].req_funct7[r*7 +: 7]    = f7;
    endtask

    task automatic drain();
        bus[0].req_valid  = 2'b00;
        bus[0].resp_ready = 2'b11;
        repeat (5) tick();
    endtask

    // Instance 1: requester 1 always valid, result always accepted, fresh operands every cycle
    initial begin
        bus[1].req_valid  = 2'b10;
        bus[1].resp_ready = 2'b10;
        forever begin
            bus[1].req_rs1    = {$urandom, $urandom};
            bus[1].req_rs2    = {$urandom, $urandom};
            bus[1].req_funct3 = 6'($urandom);
            bus[1].req_funct7 = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 7'h00};
            tick();
        end
    end

    initial begin
        bus[0].req_valid  = 2'b00;
        bus[0].resp_ready = 2'b00;
        bus[0].req_rs1    = '0;
        bus[0].req_rs2    = '0;
        bus[0].req_funct3 = '0;
        bus[0].req_funct7 = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst req_ready", bus[0].req_ready, 2'b00);
        check("rst resp_valid", bus[0].resp_valid, 2'b00);
        check("rst resp_rd", bus[0].resp_rd, 0);
        check("rst resp_z", bus[0].resp_z, 0);
        check("rst alu_rs2", bus[0].alu_rs2, 0);
        check("rst alu_funct3", bus[0].alu_funct3, 0);

        // Single request 20+30
        tick();
        set_req(0, 20, 30, 3'd0, 7'h00);
        bus[0].req_valid  = 2'b01;
        bus[0].resp_ready = 2'b01;
        @(negedge clk);
        check("single ready", bus[0].req_ready, 2'b01);
        tick();
        bus[0].req_valid = 2'b00;
        tick();
        @(negedge clk);
        check("single resp_valid", bus[0].resp_valid, 2'b01);
        check("single rd", bus[0].resp_rd, 50);
        check("single z", bus[0].resp_z, 0);
        tick();

        // Tie after reset: 8-3 on requester 0, 20-20 on requester 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 8, 3, 3'd0, 7'h20);
        set_req(1, 20, 20, 3'd0, 7'h20);
        bus[0].req_valid  = 2'b11;
        bus[0].resp_ready = 2'b11;
        @(negedge clk);
        check("tie first grant", bus[0].req_ready, 2'b01);
        tick(); tick();
        @(negedge clk);
        check("tie r0 valid", bus[0].resp_valid, 2'b01);
        check("tie r0 rd", bus[0].resp_rd, 5);
        check("tie r0 z", bus[0].resp_z, 0);
        tick();
        @(negedge clk);
        check("tie second grant", bus[0].req_ready, 2'b10);
        tick(); tick();
        @(negedge clk);
        check("tie r1 valid", bus[0].resp_valid, 2'b10);
        check("tie r1 rd", bus[0].resp_rd, 0);
        check("tie r1 z", bus[0].resp_z, 1);
        repeat (6) tick();
        drain();

        // Backpressure, then non-owner resp_ready, then owner completion
        set_req(0, 100, 23, 3'd0, 7'h00);
        bus[0].req_valid  = 2'b01;
        bus[0].resp_ready = 2'b00;
        @(negedge clk);
        check("bp grant", bus[0].req_ready, 2'b01);
        tick();
        bus[0].req_valid = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp resp_valid", bus[0].resp_valid, 2'b01);
            check("bp rd", bus[0].resp_rd, 123);
            check("bp req_ready", bus[0].req_ready, 2'b00);
            tick();
        end
        bus[0].resp_ready = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("non-owner resp_valid", bus[0].resp_valid, 2'b01);
            tick();
        end
        bus[0].resp_ready = 2'b01;
        @(negedge clk);
        check("owner resp_valid", bus[0].resp_valid, 2'b01);
        tick();
        @(negedge clk);
        check("after done resp_valid", bus[0].resp_valid, 2'b00);
        check("after done grant", bus[0].req_ready, 2'b10);
        tick();
        drain();

        // Reset mid-EXEC abandons the op and restores requester 0 priority
        set_req(0, 1, 1, 3'd0, 7'h00);
        bus[0].req_valid = 2'b01;
        @(negedge clk);
        check("abort grant", bus[0].req_ready, 2'b01);
        tick();
        bus[0].req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus[0].req_valid = 2'b11;
        @(negedge clk);
        check("abort resp_valid", bus[0].resp_valid, 2'b00);
        check("abort tie grant", bus[0].req_ready, 2'b01);
        tick();
        bus[0].req_valid = 2'b00;
        @(negedge clk);
        check("abort resp_valid late", bus[0].resp_valid, 2'b00);
        tick();
        drain();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            bus[0].req_valid  = 2'($urandom);
            bus[0].resp_ready = 2'($urandom);
            bus[0].req_rs1    = {$urandom, $urandom};
            bus[0].req_rs2    = {$urandom, $urandom};
            bus[0].req_funct3 = 6'($urandom);
            bus[0].req_funct7 = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                 ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00};
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width.
REQ-002 Parameter: ALU_LAT, default 1, cycles from driving ALU inputs to a valid alu_rd/alu_z (range 1-15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-007 req_rs1  input  2*XLEN  operand A; requester i at bits [i*XLEN +: XLEN].
REQ-008 req_rs2  input  2*XLEN  operand B, same packing.
REQ-009 req_funct3  input  6  funct3 per requester, 3 bits each.
REQ-010 req_funct7  input  14  funct7 per requester, 7 bits each.
REQ-011 resp_valid  output  2  one-hot result valid to the owning requester.
REQ-012 resp_ready  input  2  per-requester result accept.
REQ-013 resp_rd  output  XLEN  captured ALU result.
REQ-014 resp_z  output  1  captured ALU zero flag.
REQ-015 alu_rs1, alu_rs2  output  XLEN each  operands to the shared ALU.
REQ-016 alu_funct3 output 3, alu_funct7 output 7  opcode fields to the shared ALU.
REQ-017 alu_rd  input  XLEN  ALU result; alu_z  input  1  ALU zero flag.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-019 IDLE: if any req_valid bit is set, grant one requester, assert its req_ready combinationally that cycle, latch its rs1/rs2/funct3/funct7 and owner index, go to EXEC.
REQ-020 Handshake: a request is accepted only in a cycle where req_valid[i] and req_ready[i] are both 1; req_ready SHALL be 0 in EXEC and RESP.
REQ-021 Arbitration: one valid -> grant it; both valid -> grant the requester not granted last (round-robin); last-grant register updates on acceptance.
REQ-022 Fairness: a requester holding req_valid SHALL be accepted within one foreign transaction of the current one.
REQ-023 EXEC: alu_* outputs SHALL carry the latched operands; a wait counter counts ALU_LAT cycles; on its final EXEC cycle alu_rd/alu_z are captured into resp_rd/resp_z and the FSM enters RESP.
REQ-024 alu_* outputs SHALL hold the latched values in all states (stable between transactions); no combinational path from req_* to alu_*.
REQ-025 RESP: resp_valid[owner]=1, other bit 0; resp_rd/resp_z stable; on resp_ready[owner]=1 return to IDLE next cycle; resp_ready of the non-owner is ignored.
REQ-026 Latency: acceptance at cycle T -> resp_valid first high at cycle T+1+ALU_LAT; minimum issue interval 2+ALU_LAT cycles.
REQ-027 resp_valid with resp_ready already high SHALL complete in that single cycle (no bubble beyond return to IDLE).
REQ-028 Requester dropping req_valid before acceptance is legal; no state change results.
REQ-029 New requests arriving during EXEC/RESP SHALL wait; no request is lost or reordered within one requester.
REQ-030 Wait counter SHALL be ceil(log2(ALU_LAT+1)) bits wide and never wrap.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, last-grant = requester 1 (so requester 0 wins first tie), counter 0, resp_valid=0, req_ready=0 in the following cycle, resp_rd=0, resp_z=0, alu_* latches 0.
REQ-032 Reset mid-EXEC or mid-RESP SHALL abandon the transaction; no resp_valid for it is ever issued.
REQ-033 rst has priority over all other inputs in the same cycle.

Verification
REQ-034 Single request: req_valid=01, rs1=20, rs2=30, funct3=000, funct7=00, ALU_LAT=1 -> req_ready=01 at T, resp_valid=01 at T+2, resp_rd=50, resp_z=0.
REQ-035 Tie after reset: req_valid=11 held, both with SUB (funct7=20) 8-3 and 20-20 -> requester 0 served first (rd=5, z=0), then requester 1 (rd=0, z=1), grants alternate thereafter.
REQ-036 Backpressure: resp_ready=00 held 5 cycles in RESP -> resp_valid stays 01, resp_rd unchanged, req_ready stays 00; on resp_ready=01 -> IDLE next cycle.
REQ-037 Reset mid-EXEC: assert rst for one cycle during EXEC -> resp_valid never asserts for that op, next tie goes to requester 0.
REQ-038 ALU_LAT=3 build: back-to-back requests from requester 1 with resp_ready=10 tied high -> accepts every 5 cycles, resp_valid=10 exactly 4 cycles after each acceptance.
REQ-039 Non-owner resp_ready: owner 0 in RESP, resp_ready=10 -> no completion, resp_valid stays 01.
